// File: rtl/lock_entry_sequencer.sv
// Entry sequencer for the 4-bit digital lock. It collects a code from two pushbuttons, issues the attempt, and relocks the lock or clears a lockout.
// Optional macro DEBOUNCE_EN adds a stability filter of DEBOUNCE_CYC cycles on each synchronized button.
`timescale 1ns/1ps

module lock_entry_sequencer #(
    parameter int unsigned ENTRY_TIMEOUT = 1000,
    parameter int unsigned UNLOCK_HOLD   = 500,
    parameter int unsigned COOLDOWN_CYC  = 2000
`ifdef DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYC  = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn0_raw,
    input  logic       btn1_raw,
    input  logic       btn_clr,
    input  logic       unlock_led,
    input  logic       lockout_led,
    output logic       enter,
    output logic [3:0] code_out,
    output logic       admin_reset,
    output logic [2:0] digit_cnt,
    output logic       busy
);

    localparam int unsigned MAX_AB  = (ENTRY_TIMEOUT > UNLOCK_HOLD) ? ENTRY_TIMEOUT : UNLOCK_HOLD;
    localparam int unsigned MAX_CYC = (MAX_AB > COOLDOWN_CYC) ? MAX_AB : COOLDOWN_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_UNLOCKED,
        S_COOLDOWN,
        S_RELOCK
    } state_t;

    state_t             state;
    logic [2:0]         shift_reg;
    logic [CNT_W-1:0]   cnt;

    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         btn_s;
    logic [1:0]         btn_prev;
    logic [1:0]         press_c;
    logic               one_press_c;
    logic               both_press_c;

    // Two-flop synchronizer, bit 1 = btn1, bit 0 = btn0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {btn1_raw, btn0_raw};
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      db_level;

    // A level change is accepted only after DEBOUNCE_CYC consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
            db_level  <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_s = db_level;
`else
    assign btn_s = sync2;
`endif

    // Edge history runs in every state so a button held across busy is never counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev <= 2'b00;
        end else begin
            btn_prev <= btn_s;
        end
    end

    assign press_c      = btn_s & ~btn_prev;
    assign one_press_c  = ^press_c;
    assign both_press_c = &press_c;

    // Main sequencer; the fourth digit goes straight to code_out, so only three are stored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_COLLECT;
            shift_reg   <= 3'b000;
            cnt         <= '0;
            enter       <= 1'b0;
            code_out    <= 4'b0000;
            admin_reset <= 1'b0;
            digit_cnt   <= 3'd0;
            busy        <= 1'b0;
        end else begin
            enter       <= 1'b0;
            admin_reset <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (btn_clr || both_press_c) begin
                        shift_reg <= 3'b000;
                        digit_cnt <= 3'd0;
                        cnt       <= '0;
                    end else if (one_press_c) begin
                        cnt       <= '0;
                        shift_reg <= {shift_reg[1:0], press_c[1]};
                        if (digit_cnt == 3'd3) begin
                            digit_cnt <= 3'd4;
                            code_out  <= {shift_reg, press_c[1]};
                            enter     <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end else if (digit_cnt != 3'd0) begin
                        if (cnt >= CNT_W'(ENTRY_TIMEOUT - 1)) begin
                            shift_reg <= 3'b000;
                            digit_cnt <= 3'd0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                S_ISSUE: begin
                    state <= S_WAIT;
                end

                // Lock status is valid in this cycle; lockout outranks unlock
                S_WAIT: begin
                    shift_reg <= 3'b000;
                    digit_cnt <= 3'd0;
                    code_out  <= 4'b0000;
                    cnt       <= '0;
                    if (lockout_led) begin
                        state <= S_COOLDOWN;
                    end else if (unlock_led) begin
                        state <= S_UNLOCKED;
                    end else begin
                        state <= S_COLLECT;
                        busy  <= 1'b0;
                    end
                end

                S_UNLOCKED: begin
                    if (btn_clr || (cnt == CNT_W'(UNLOCK_HOLD - 1))) begin
                        cnt   <= '0;
                        state <= S_RELOCK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_COOLDOWN: begin
                    if (cnt == CNT_W'(COOLDOWN_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_RELOCK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // The strobe register lags the state by one cycle, so it fires as COLLECT resumes
                S_RELOCK: begin
                    admin_reset <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_COLLECT;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule
